// File: rtl/servant_uart_pkg.sv
// Shared definitions for the servant UART receiver.
//   - rx_state_e : receive FSM encoding (2 bits)
//   - ADR_*      : Wishbone register select values
//   - ST_*       : STATUS register bit positions
package servant_uart_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    localparam logic ADR_DATA   = 1'b0;
    localparam logic ADR_STATUS = 1'b1;

    localparam int ST_VALID   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVR     = 2;
    localparam int ST_FERR    = 3;
    localparam int ST_CNT_LSB = 4;

    // Baud counter width; covers BAUD_DIV up to 65535.
    localparam int BAUD_CW = 16;

endpackage

// File: rtl/servant_uart_rx_fifo.sv
// Small synchronous FIFO holding received bytes.
//   clk, rst_n : clock, async active-low reset (resets empty)
//   push, din  : write request and data (ignored when full unless popping)
//   pop        : read request (ignored when empty)
//   dout       : head entry, 0 when empty
//   empty,full : status flags
//   count      : fill level, AW+1 bits
module servant_uart_rx_fifo #(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count
);

    localparam int          DEPTH    = 1 << AW;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // A pop frees a slot in the same cycle, so a push into a full FIFO
    // is still accepted when paired with a pop.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign dout = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/servant_uart_rx.sv
// Wishbone-responder 8N1 UART receiver for the servant SoC.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_rx           : serial input, idle high, asynchronous
//   i_wb_adr       : 0 = DATA (pop FIFO head), 1 = STATUS
//   i_wb_dat       : write data; STATUS bits 2/3 are write-1-to-clear
//   i_wb_we        : write enable
//   i_wb_cyc       : cycle/strobe
//   o_wb_rdt       : read data, combinational from i_wb_adr
//   o_wb_ack       : one-cycle registered acknowledge
//   o_irq          : high while the receive FIFO holds data
module servant_uart_rx
    import servant_uart_pkg::*;
#(
    parameter int BAUD_DIV = 278,
    parameter int FIFO_AW  = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_rx,
    input  logic        i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_irq
);

    localparam logic [BAUD_CW-1:0] HALF_LOAD = BAUD_CW'(BAUD_DIV/2 - 1);
    localparam logic [BAUD_CW-1:0] FULL_LOAD = BAUD_CW'(BAUD_DIV - 1);

    // ---------------- input synchronizer ----------------
    logic [1:0] sync;
    logic       rxs;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) sync <= 2'b11;
        else          sync <= {sync[0], i_rx};
    end
    assign rxs = sync[1];

    // ---------------- receive FSM ----------------
    rx_state_e          state, state_nxt;
    logic [BAUD_CW-1:0] baud_cnt;
    logic [2:0]         bit_cnt;
    logic [7:0]         shreg;
    logic               baud_zero;

    logic ld_half, ld_full, cnt_dec, shift, stop_ok, stop_bad;

    assign baud_zero = (baud_cnt == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= RX_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RX_IDLE:  if (!rxs) state_nxt = RX_START;
            // A start bit that is high again at mid-bit was a glitch.
            RX_START: if (baud_zero) state_nxt = rxs ? RX_IDLE : RX_DATA;
            RX_DATA:  if (baud_zero && bit_cnt == 3'd7) state_nxt = RX_STOP;
            RX_STOP:  if (baud_zero) state_nxt = RX_IDLE;
            default:  state_nxt = RX_IDLE;
        endcase
    end

    always_comb begin
        ld_half  = 1'b0;
        ld_full  = 1'b0;
        cnt_dec  = 1'b0;
        shift    = 1'b0;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        unique case (state)
            RX_IDLE:  ld_half = ~rxs;
            RX_START: if (baud_zero) ld_full = ~rxs; else cnt_dec = 1'b1;
            RX_DATA:  if (baud_zero) begin
                          shift   = 1'b1;
                          ld_full = 1'b1;
                      end else cnt_dec = 1'b1;
            RX_STOP:  if (baud_zero) begin
                          stop_ok  = rxs;
                          stop_bad = ~rxs;
                      end else cnt_dec = 1'b1;
            default:  ;
        endcase
    end

    // Counters and shift register; half-period load on the start edge
    // puts every later sample in the middle of its bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            if (ld_half) begin
                baud_cnt <= HALF_LOAD;
                bit_cnt  <= '0;
            end else if (ld_full) begin
                baud_cnt <= FULL_LOAD;
            end else if (cnt_dec) begin
                baud_cnt <= baud_cnt - 1'b1;
            end
            if (shift) begin
                shreg   <= {rxs, shreg[7:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    // ---------------- FIFO ----------------
    logic [7:0]       fifo_dout;
    logic             fifo_empty, fifo_full;
    logic [FIFO_AW:0] fifo_count;
    logic             pop_req;

    servant_uart_rx_fifo #(
        .DW (8),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (stop_ok),
        .pop   (pop_req),
        .din   (shreg),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // ---------------- Wishbone ----------------
    logic ovr, ferr, ovr_set, w1c;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) o_wb_ack <= 1'b0;
        else          o_wb_ack <= i_wb_cyc & ~o_wb_ack;
    end

    // ack can only be high when cyc started the access, so side effects
    // key off ack alone.
    assign pop_req = o_wb_ack & ~i_wb_we & (i_wb_adr == ADR_DATA);
    assign w1c     = o_wb_ack &  i_wb_we & (i_wb_adr == ADR_STATUS);

    // A same-cycle pop makes room, so that push is not an overrun.
    assign ovr_set = stop_ok & fifo_full & ~pop_req;

    // Set takes priority over a simultaneous write-1-to-clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ovr  <= 1'b0;
            ferr <= 1'b0;
        end else begin
            if (ovr_set)                   ovr <= 1'b1;
            else if (w1c && i_wb_dat[ST_OVR])  ovr <= 1'b0;
            if (stop_bad)                  ferr <= 1'b1;
            else if (w1c && i_wb_dat[ST_FERR]) ferr <= 1'b0;
        end
    end

    always_comb begin
        o_wb_rdt = '0;
        if (i_wb_adr == ADR_DATA) begin
            o_wb_rdt[7:0] = fifo_dout;
        end else begin
            o_wb_rdt[ST_VALID]                   = ~fifo_empty;
            o_wb_rdt[ST_FULL]                    = fifo_full;
            o_wb_rdt[ST_OVR]                     = ovr;
            o_wb_rdt[ST_FERR]                    = ferr;
            o_wb_rdt[ST_CNT_LSB +: FIFO_AW+1]    = fifo_count;
        end
    end

    // Decoded from the registered FIFO count only; no bus-to-irq path.
    assign o_irq = ~fifo_empty;

    logic unused_dat;
    assign unused_dat = ^{i_wb_dat[31:4], i_wb_dat[1:0]};

endmodule
